// File: rtl/edge_pulse_pkg.sv
// Shared types and defaults for the edge pulse generator.
// Optional input synchroniser is selected by the EDGE_PULSE_SYNC_EN macro.
package edge_pulse_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_e;

endpackage

// File: rtl/edge_pulse_ch.sv
// One channel: optional 2-flop synchroniser (EDGE_PULSE_SYNC_EN), edge detect,
// retriggerable pulse-length down-counter and sticky retrigger flag.
module edge_pulse_ch
    import edge_pulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  edge_mode_e       i_mode,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_clr,
    output logic             o_pulse,
    output logic             o_ovr,
    output logic             o_pulse_nxt
);

    logic             w_smp;
    logic             w_rise;
    logic             w_fall;
    logic             w_trig;
    logic             w_pulse_nxt;
    logic [CNT_W-1:0] w_load;
    logic             r_en_q;
    logic             r_pulse;
    logic             r_ovr;
    logic [CNT_W-1:0] r_cnt;

`ifdef EDGE_PULSE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchroniser ahead of edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_en;
            r_sync2 <= r_sync1;
        end
    end

    assign w_smp = r_sync2;
`else
    assign w_smp = i_en;
`endif

    assign w_rise = w_smp & ~r_en_q;
    assign w_fall = ~w_smp & r_en_q;

    // Edge qualification by mode; OFF blocks triggers but en_q keeps tracking.
    always_comb begin
        w_trig = 1'b0;
        case (i_mode)
            EDGE_RISE: w_trig = w_rise;
            EDGE_FALL: w_trig = w_fall;
            EDGE_BOTH: w_trig = w_rise | w_fall;
            EDGE_OFF:  w_trig = 1'b0;
            default:   w_trig = 1'b0;
        endcase
    end

    // Length 0 behaves as 1, so the reload value saturates at zero.
    always_comb begin
        w_load = {CNT_W{1'b0}};
        if (i_len != {CNT_W{1'b0}}) begin
            w_load = i_len - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_load = {CNT_W{1'b0}};
        end
    end

    assign w_pulse_nxt = w_trig | (r_pulse & (r_cnt != {CNT_W{1'b0}}));

    // Pulse state, counter and sticky retrigger flag (set beats clear).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en_q  <= 1'b0;
            r_pulse <= 1'b0;
            r_ovr   <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_en_q  <= w_smp;
            r_pulse <= w_pulse_nxt;
            r_ovr   <= (r_ovr & ~i_clr) | (w_trig & r_pulse);
            if (w_trig) begin
                r_cnt <= w_load;
            end else if (r_cnt != {CNT_W{1'b0}}) begin
                r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign o_pulse     = r_pulse;
    assign o_ovr       = r_ovr;
    assign o_pulse_nxt = w_pulse_nxt;

endmodule

// File: rtl/edge_pulse_generator.sv
// Multi-channel edge-to-pulse generator with shared pulse length.
// Define EDGE_PULSE_SYNC_EN to add a 2-flop synchroniser on every input.
module edge_pulse_generator
    import edge_pulse_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                CLK_I,
    input  logic                RST_NI,
    input  logic [NUM_CH-1:0]   EN_I,
    input  logic [2*NUM_CH-1:0] MODE_I,
    input  logic [CNT_W-1:0]    LEN_I,
    input  logic                CLR_I,
    output logic [NUM_CH-1:0]   PULSE_O,
    output logic [NUM_CH-1:0]   OVR_O,
    output logic                ANY_O
);

    logic [NUM_CH-1:0] w_pulse;
    logic [NUM_CH-1:0] w_ovr;
    logic [NUM_CH-1:0] w_pulse_nxt;
    logic              r_any;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        edge_pulse_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clk       (CLK_I),
            .i_rst_n     (RST_NI),
            .i_en        (EN_I[g]),
            .i_mode      (edge_mode_e'(MODE_I[2*g +: 2])),
            .i_len       (LEN_I),
            .i_clr       (CLR_I),
            .o_pulse     (w_pulse[g]),
            .o_ovr       (w_ovr[g]),
            .o_pulse_nxt (w_pulse_nxt[g])
        );
    end

    // ANY is built from next-state bits so it lines up with PULSE_O.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_pulse_nxt;
        end
    end

    assign PULSE_O = w_pulse;
    assign OVR_O   = w_ovr;
    assign ANY_O   = r_any;

endmodule

// File: tb/tb_edge_pulse_generator.sv
// Directed self-checking bench for edge_pulse_generator (default 4 ch, CNT_W 4).
module tb_edge_pulse_generator;

    logic       CLK_I;
    logic       RST_NI;
    logic [3:0] EN_I;
    logic [7:0] MODE_I;
    logic [3:0] LEN_I;
    logic       CLR_I;
    logic [3:0] PULSE_O;
    logic [3:0] OVR_O;
    logic       ANY_O;

    int n_vec;
    int n_err;

`ifdef EDGE_PULSE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    edge_pulse_generator #(.NUM_CH(4), .CNT_W(4)) dut (
        .CLK_I   (CLK_I),
        .RST_NI  (RST_NI),
        .EN_I    (EN_I),
        .MODE_I  (MODE_I),
        .LEN_I   (LEN_I),
        .CLR_I   (CLR_I),
        .PULSE_O (PULSE_O),
        .OVR_O   (OVR_O),
        .ANY_O   (ANY_O)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        RST_NI = 1'b0;
        EN_I   = 4'b0000;
        MODE_I = 8'b0000_0000;
        LEN_I  = 4'd0;
        CLR_I  = 1'b0;
        tick();
        tick();
        chk("rst_pulse", {28'd0, PULSE_O}, 32'h0);
        chk("rst_ovr",   {28'd0, OVR_O},   32'h0);
        chk("rst_any",   {31'd0, ANY_O},   32'h0);
        RST_NI = 1'b1;
        tick();
        tick();

        // Ch0 rise, LEN 3; LEN change mid-pulse must not shorten it.
        LEN_I   = 4'd3;
        EN_I[0] = 1'b1;
        tick();
        for (int i = 0; i < LAT; i++) tick();
        chk("a_p1",  {28'd0, PULSE_O}, 32'h1);
        chk("a_any", {31'd0, ANY_O},   32'h1);
        LEN_I = 4'd0;
        tick();
        chk("a_p2", {28'd0, PULSE_O}, 32'h1);
        tick();
        chk("a_p3", {28'd0, PULSE_O}, 32'h1);
        tick();
        chk("a_end",     {28'd0, PULSE_O}, 32'h0);
        chk("a_any_end", {31'd0, ANY_O},   32'h0);
        chk("a_ovr",     {28'd0, OVR_O},   32'h0);

        // Ch1 fall, LEN 0: rising edge ignored, falling edge gives 1 cycle.
        MODE_I  = 8'b0000_0100;
        EN_I[1] = 1'b1;
        tick();
        chk("b_rise_none", {28'd0, PULSE_O}, 32'h0);
        tick();
        chk("b_rise_none2", {28'd0, PULSE_O}, 32'h0);
        EN_I[1] = 1'b0;
        tick();
        chk("b_fall", {28'd0, PULSE_O}, 32'h2);
        tick();
        chk("b_fall_end", {28'd0, PULSE_O}, 32'h0);

        // Ch2 rise, LEN 4, retrigger 2 cycles later -> 6 cycles, OVR set.
        MODE_I  = 8'b0000_0000;
        LEN_I   = 4'd4;
        EN_I[2] = 1'b1;
        tick();
        chk("c_p1",   {28'd0, PULSE_O}, 32'h4);
        chk("c_ovr0", {28'd0, OVR_O},   32'h0);
        EN_I[2] = 1'b0;
        tick();
        chk("c_p2", {28'd0, PULSE_O}, 32'h4);
        EN_I[2] = 1'b1;
        tick();
        chk("c_p3",   {28'd0, PULSE_O}, 32'h4);
        chk("c_ovr1", {28'd0, OVR_O},   32'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("c_hold", {28'd0, PULSE_O}, 32'h4);
        end
        tick();
        chk("c_end",     {28'd0, PULSE_O}, 32'h0);
        chk("c_ovr_stk", {28'd0, OVR_O},   32'h4);
        CLR_I = 1'b1;
        tick();
        CLR_I = 1'b0;
        chk("c_clr", {28'd0, OVR_O}, 32'h0);

        // Clear coincident with retrigger: set wins.
        EN_I[2] = 1'b0;
        tick();
        EN_I[2] = 1'b1;
        tick();
        EN_I[2] = 1'b0;
        tick();
        EN_I[2] = 1'b1;
        CLR_I   = 1'b1;
        tick();
        CLR_I = 1'b0;
        chk("d_setwins", {28'd0, OVR_O}, 32'h4);
        CLR_I = 1'b1;
        tick();
        CLR_I = 1'b0;
        chk("d_clr", {28'd0, OVR_O}, 32'h0);
        tick();
        tick();
        tick();
        chk("d_end", {28'd0, PULSE_O}, 32'h0);

        // Ch3 both, LEN 2, toggling each cycle -> continuous pulse.
        MODE_I = 8'b1000_0000;
        LEN_I  = 4'd2;
        for (int i = 0; i < 8; i++) begin
            EN_I[3] = ~EN_I[3];
            tick();
            chk("e_tog_p",   {28'd0, PULSE_O}, 32'h8);
            chk("e_tog_any", {31'd0, ANY_O},   32'h1);
        end
        tick();
        chk("e_tail", {28'd0, PULSE_O}, 32'h8);
        tick();
        chk("e_end",     {28'd0, PULSE_O}, 32'h0);
        chk("e_any_end", {31'd0, ANY_O},   32'h0);

        // Ch0 off mode: no trigger, en_q tracks so re-enabling is quiet.
        MODE_I  = 8'b0000_0000;
        EN_I[0] = 1'b0;
        tick();
        MODE_I  = 8'b0000_0011;
        EN_I[0] = 1'b1;
        tick();
        chk("f_off", {28'd0, PULSE_O}, 32'h0);
        MODE_I = 8'b0000_0000;
        tick();
        chk("f_track", {28'd0, PULSE_O}, 32'h0);

        // LEN 5 pulse, async reset in its second cycle.
        LEN_I   = 4'd5;
        EN_I[0] = 1'b0;
        tick();
        EN_I[0] = 1'b1;
        tick();
        chk("g_p1", {28'd0, PULSE_O}, 32'h1);
        tick();
        chk("g_p2", {28'd0, PULSE_O}, 32'h1);
        #2;
        RST_NI = 1'b0;
        EN_I   = 4'b0000;
        #1;
        chk("g_async_p",   {28'd0, PULSE_O}, 32'h0);
        chk("g_async_any", {31'd0, ANY_O},   32'h0);
        tick();
        RST_NI = 1'b1;
        tick();
        tick();
        chk("g_no_resume", {28'd0, PULSE_O}, 32'h0);

        // Input held high across reset release gives one pulse.
        LEN_I  = 4'd1;
        RST_NI = 1'b0;
        EN_I   = 4'b0100;
        tick();
        RST_NI = 1'b1;
        tick();
        chk("h_rel", {28'd0, PULSE_O}, 32'h4);
        tick();
        chk("h_end", {28'd0, PULSE_O}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
